// File: rtl/xup_vector_bit_scanner.sv
// ----------------------------------------------------------------------------
// xup_vector_bit_scanner
//
// Purpose:
//   Captures a SIZE-bit vector on load. It then emits the indices of its set
//   bits one at a time, lowest index first, over a valid/ready handshake.
//   When the last index has been taken, it raises a one-cycle done pulse.
//   An all-zero vector goes straight to the done pulse without emitting
//   anything.
//
// Ports:
//   clk        - sole clock, all state updates on its rising edge
//   reset      - synchronous active-high reset
//   load       - capture vin and start a scan (honoured only while idle)
//   vin        - vector to decompose into set-bit indices
//   busy       - high while a scan is in progress or completing
//   idx_valid  - idx holds a valid set-bit index
//   idx_ready  - consumer accepts idx this cycle
//   idx        - lowest remaining set-bit index
//   last       - idx is the final remaining set bit
//   done       - one-cycle completion pulse
//   count      - indices transferred in the current or most recent scan
// ----------------------------------------------------------------------------
module xup_vector_bit_scanner #(
   parameter  int SIZE = 8,
   localparam int IDXW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [SIZE-1:0] vin,
   output logic            busy,
   output logic            idx_valid,
   input  logic            idx_ready,
   output logic [IDXW-1:0] idx,
   output logic            last,
   output logic            done,
   output logic [IDXW:0]   count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [SIZE-1:0] VEC_ONE = {{(SIZE-1){1'b0}}, 1'b1};
   localparam logic [IDXW:0]   CNT_ONE = {{IDXW{1'b0}}, 1'b1};

   state_t          state;
   logic [SIZE-1:0] vreg;
   logic [SIZE-1:0] vreg_rest;

   // Clearing the lowest set bit is a single subtract-and-mask. The same
   // term also tells us whether exactly one bit remains.
   assign vreg_rest = vreg & (vreg - VEC_ONE);

   // idx and last depend only on the captured vector and registered flags.
   // This keeps idx_ready off any combinational path to the outputs. The
   // register is zero whenever no scan is active, so idx reads zero there.
   assign last = idx_valid && (vreg_rest == '0);

   // Priority encoder for the lowest set bit. The loop walks downward so
   // that the lowest set bit is the last one to write idx.
   always_comb begin
      idx = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (vreg[i]) begin
            idx = IDXW'(i);
         end
      end
   end

   // Scan controller. busy, idx_valid and done are registered alongside the
   // state so they change cleanly on the clock edge. Reset overrides any
   // load or transfer in the same cycle and gives no done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         vreg      <= '0;
         count     <= '0;
         busy      <= 1'b0;
         idx_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  vreg  <= vin;
                  count <= '0;
                  busy  <= 1'b1;
                  if (vin != '0) begin
                     state     <= SCAN;
                     idx_valid <= 1'b1;
                     done      <= 1'b0;
                  end else begin
                     state     <= DONE;
                     idx_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (idx_ready) begin
                  vreg  <= vreg_rest;
                  count <= count + CNT_ONE;
                  if (last) begin
                     state     <= DONE;
                     idx_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               vreg      <= '0;
               busy      <= 1'b0;
               idx_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule
